// File: rtl/traffic_pkg.sv
// Shared traffic-light constants: interval and selector codes,
// default durations and LED patterns used by the timer and the FSM.
package traffic_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_RSVD = 2'b11;

  localparam logic [1:0] SEL_BASE     = 2'b00;
  localparam logic [1:0] SEL_EXT      = 2'b01;
  localparam logic [1:0] SEL_YEL      = 2'b10;
  localparam logic [1:0] SEL_DEFAULTS = 2'b11;

  localparam int DEF_BASE = 6;
  localparam int DEF_EXT  = 3;
  localparam int DEF_YEL  = 2;

  localparam logic [2:0] LED_OFF = 3'b000;
  localparam logic [2:0] LED_GRN = 3'b001;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_RED = 3'b100;

endpackage

// File: rtl/sec_tick_gen.sv
// 1 s timebase: prescaler 0..TICK_DIV-1 with sync clear and enable.
// Ports: clk, rst_n (async low), clr, en in; tick out (last count).
module sec_tick_gen
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;

  assign tick = en && (pre_q == LAST);

  // disabled means held at zero, so each run starts a fresh second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (clr || !en || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer for the traffic FSM: three programmable durations,
// seconds countdown, Expired pulse. Ports: clk, Reset_n, Start_Timer,
// Interval, Sync_Reprogram, Selector, Time_Value in; Expired, Busy out;
// Remaining out only when REMAINING_OUT_EN is defined.
module interval_timer_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int TW       = 4,
  parameter int T_BASE   = DEF_BASE,
  parameter int T_EXT    = DEF_EXT,
  parameter int T_YEL    = DEF_YEL
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          Start_Timer,
  input  logic [1:0]    Interval,
  input  logic          Sync_Reprogram,
  input  logic [1:0]    Selector,
  input  logic [TW-1:0] Time_Value,
  output logic          Expired,
  output logic          Busy
`ifdef REMAINING_OUT_EN
  ,
  output logic [TW-1:0] Remaining
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [TW-1:0] D_BASE = TW'(T_BASE);
  localparam logic [TW-1:0] D_EXT  = TW'(T_EXT);
  localparam logic [TW-1:0] D_YEL  = TW'(T_YEL);
  localparam logic [TW-1:0] ONE    = TW'(1);

  logic [0:0]    state_q;
  logic [TW-1:0] dur_base;
  logic [TW-1:0] dur_ext;
  logic [TW-1:0] dur_yel;
  logic [TW-1:0] count_q;
  logic          exp_q;
  logic          tick;
  logic          run;
  logic          fin;
  logic [TW-1:0] dsel;
  logic [TW-1:0] load;

  assign run = (state_q == S_RUN);

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(Reset_n),
    .clr  (Start_Timer),
    .en   (run),
    .tick (tick)
  );

  // reserved Interval code falls back to base
  always_comb begin
    dsel = dur_base;
    unique case (Interval)
      INT_EXT: dsel = dur_ext;
      INT_YEL: dsel = dur_yel;
      default: dsel = dur_base;
    endcase
  end

  assign load = (dsel == '0) ? ONE : dsel;

  // a same-cycle Start aborts the run, so no Expired for it
  assign fin = run && tick && (count_q <= ONE) && !Start_Timer;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      exp_q <= fin;
      if (Start_Timer) begin
        state_q <= S_RUN;
        count_q <= load;
      end else if (run && tick) begin
        if (count_q <= ONE) begin
          state_q <= S_IDLE;
          count_q <= '0;
        end else begin
          count_q <= count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dur_base <= D_BASE;
      dur_ext  <= D_EXT;
      dur_yel  <= D_YEL;
    end else if (Sync_Reprogram) begin
      unique case (Selector)
        SEL_BASE: dur_base <= Time_Value;
        SEL_EXT:  dur_ext  <= Time_Value;
        SEL_YEL:  dur_yel  <= Time_Value;
        default: begin
          dur_base <= D_BASE;
          dur_ext  <= D_EXT;
          dur_yel  <= D_YEL;
        end
      endcase
    end
  end

  assign Expired = exp_q;
  assign Busy    = run;

`ifdef REMAINING_OUT_EN
  assign Remaining = count_q;
`endif

endmodule
